// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: per-mode timing record, the standard mode table and the
// legacy 800x600@60 constants.
package vga_pkg;

  localparam int unsigned MODE_FIELD_W  = 11;
  localparam int unsigned VGA_NUM_MODES = 3;

  localparam logic [1:0] MODE_800X600  = 2'd0;
  localparam logic [1:0] MODE_640X480  = 2'd1;
  localparam logic [1:0] MODE_1024X768 = 2'd2;

  // Legacy single-mode constants, identical to mode 0.
  localparam int unsigned H_ADDR       = 800;
  localparam int unsigned H_SYNC_START = 840;
  localparam int unsigned H_SYNC_TIME  = 128;
  localparam int unsigned H_TOTAL      = 1056;
  localparam int unsigned V_ADDR       = 600;
  localparam int unsigned V_SYNC_START = 601;
  localparam int unsigned V_SYNC_TIME  = 4;
  localparam int unsigned V_TOTAL      = 628;

  typedef struct packed {
    logic [MODE_FIELD_W-1:0] h_addr;
    logic [MODE_FIELD_W-1:0] h_sync_start;
    logic [MODE_FIELD_W-1:0] h_sync_time;
    logic [MODE_FIELD_W-1:0] h_total;
    logic [MODE_FIELD_W-1:0] v_addr;
    logic [MODE_FIELD_W-1:0] v_sync_start;
    logic [MODE_FIELD_W-1:0] v_sync_time;
    logic [MODE_FIELD_W-1:0] v_total;
    logic                    h_pol;  // 1: sync pulse is high
    logic                    v_pol;
  } vga_mode_t;

  typedef vga_mode_t [VGA_NUM_MODES-1:0] vga_mode_tbl_t;

  function automatic vga_mode_t mk_mode(int unsigned ha, int unsigned hs, int unsigned hw,
                                        int unsigned ht, int unsigned va, int unsigned vs,
                                        int unsigned vw, int unsigned vt, bit hp, bit vp);
    vga_mode_t m;
    m.h_addr       = MODE_FIELD_W'(ha);
    m.h_sync_start = MODE_FIELD_W'(hs);
    m.h_sync_time  = MODE_FIELD_W'(hw);
    m.h_total      = MODE_FIELD_W'(ht);
    m.v_addr       = MODE_FIELD_W'(va);
    m.v_sync_start = MODE_FIELD_W'(vs);
    m.v_sync_time  = MODE_FIELD_W'(vw);
    m.v_total      = MODE_FIELD_W'(vt);
    m.h_pol        = hp;
    m.v_pol        = vp;
    return m;
  endfunction

  localparam vga_mode_tbl_t VGA_MODES = {
    mk_mode(1024, 1048, 136, 1344, 768, 771, 6, 806, 1'b0, 1'b0),
    mk_mode(640, 656, 96, 800, 480, 490, 2, 525, 1'b0, 1'b0),
    mk_mode(H_ADDR, H_SYNC_START, H_SYNC_TIME, H_TOTAL,
            V_ADDR, V_SYNC_START, V_SYNC_TIME, V_TOTAL, 1'b1, 1'b1)
  };

  // Out-of-table indices fall back to entry 0 so the lookup never selects past the table.
  function automatic vga_mode_t mode_lookup(vga_mode_tbl_t tbl, logic [1:0] idx);
    vga_mode_t m;
    case (idx)
      2'd1:    m = tbl[1];
      2'd2:    m = tbl[2];
      default: m = tbl[0];
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter with wrap at a terminal value, registered sync and blank
// flags computed from the next count so flags and count describe the same position.
module vga_axis_cnt #(
  parameter int unsigned Width   = 11,
  parameter logic        SyncRst = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] term_i,
  input  logic [Width-1:0] addr_i,
  input  logic [Width-1:0] sync_start_i,
  input  logic [Width-1:0] sync_time_i,
  input  logic             sync_inv_i,
  output logic             wrap_o,
  output logic [Width-1:0] count_o,
  output logic             sync_o,
  output logic             blank_o
);

  logic [Width-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             blank_q, blank_d;
  logic [Width:0]   sync_end;

  assign wrap_o = en_i && (count_q == term_i);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = wrap_o ? '0 : count_q + Width'(1);
    end
    sync_end = {1'b0, sync_start_i} + {1'b0, sync_time_i};
    sync_d   = ((count_d >= sync_start_i) && ({1'b0, count_d} < sync_end)) ^ sync_inv_i;
    blank_d  = (count_d >= addr_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      sync_q  <= SyncRst;
      blank_q <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blank_o = blank_q;

endmodule

// File: rtl/vga_timing_multi.sv
// Multi-mode VGA timing generator; mode changes are applied only at the frame boundary.
// Define VGA_SYNC_POL_EN to drive hsync/vsync with the per-mode polarity bits.
module vga_timing_multi
  import vga_pkg::*;
#(
  parameter int unsigned   CNT_WIDTH  = 11,
  parameter int unsigned   NUM_MODES  = 3,
  parameter int unsigned   RESET_MODE = 0,
  parameter vga_mode_tbl_t MODE_TABLE = VGA_MODES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode_sel,
  output logic [CNT_WIDTH-1:0] hcount,
  output logic [CNT_WIDTH-1:0] vcount,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 hblnk,
  output logic                 vblnk,
  output logic                 frame_start,
  output logic [1:0]           active_mode
);

  localparam logic [1:0] RstMode = 2'(RESET_MODE);

  logic [1:0] pending_q, pending_d;
  logic [1:0] active_q, active_d;
  logic       started_q;
  logic       frame_start_q, frame_start_d;
  logic       h_wrap, frame_wrap;
  logic       h_inv, v_inv;
  vga_mode_t  cur_mode, nxt_mode;

  // cur_mode decides where the counters wrap; nxt_mode describes the pixel being produced.
  assign cur_mode = mode_lookup(MODE_TABLE, active_q);
  assign nxt_mode = mode_lookup(MODE_TABLE, active_d);

`ifdef VGA_SYNC_POL_EN
  localparam vga_mode_t RstCfg   = mode_lookup(MODE_TABLE, RstMode);
  localparam logic      HSyncRst = ~RstCfg.h_pol;
  localparam logic      VSyncRst = ~RstCfg.v_pol;
  assign h_inv = ~nxt_mode.h_pol;
  assign v_inv = ~nxt_mode.v_pol;
`else
  localparam logic      HSyncRst = 1'b0;
  localparam logic      VSyncRst = 1'b0;
  assign h_inv = 1'b0;
  assign v_inv = 1'b0;
`endif

  always_comb begin
    pending_d = pending_q;
    if (32'(mode_sel) < NUM_MODES) begin
      pending_d = mode_sel;
    end
    active_d      = frame_wrap ? pending_q : active_q;
    // The first cycle out of reset presents pixel (0,0) as a new frame.
    frame_start_d = ~started_q | frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= RstMode;
      active_q      <= RstMode;
      started_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      active_q      <= active_d;
      started_q     <= 1'b1;
      frame_start_q <= frame_start_d;
    end
  end

  vga_axis_cnt #(
    .Width   (CNT_WIDTH),
    .SyncRst (HSyncRst)
  ) u_h_axis (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (started_q),
    .term_i       (CNT_WIDTH'(cur_mode.h_total) - CNT_WIDTH'(1)),
    .addr_i       (CNT_WIDTH'(nxt_mode.h_addr)),
    .sync_start_i (CNT_WIDTH'(nxt_mode.h_sync_start)),
    .sync_time_i  (CNT_WIDTH'(nxt_mode.h_sync_time)),
    .sync_inv_i   (h_inv),
    .wrap_o       (h_wrap),
    .count_o      (hcount),
    .sync_o       (hsync),
    .blank_o      (hblnk)
  );

  vga_axis_cnt #(
    .Width   (CNT_WIDTH),
    .SyncRst (VSyncRst)
  ) u_v_axis (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (h_wrap),
    .term_i       (CNT_WIDTH'(cur_mode.v_total) - CNT_WIDTH'(1)),
    .addr_i       (CNT_WIDTH'(nxt_mode.v_addr)),
    .sync_start_i (CNT_WIDTH'(nxt_mode.v_sync_start)),
    .sync_time_i  (CNT_WIDTH'(nxt_mode.v_sync_time)),
    .sync_inv_i   (v_inv),
    .wrap_o       (frame_wrap),
    .count_o      (vcount),
    .sync_o       (vsync),
    .blank_o      (vblnk)
  );

  logic unused_mode_bits;
  assign unused_mode_bits = ^{cur_mode.h_addr, cur_mode.h_sync_start, cur_mode.h_sync_time,
                              cur_mode.v_addr, cur_mode.v_sync_start, cur_mode.v_sync_time,
                              cur_mode.h_pol, cur_mode.v_pol, nxt_mode.h_total,
                              nxt_mode.v_total, nxt_mode.h_pol, nxt_mode.v_pol};

  assign frame_start = frame_start_q;
  assign active_mode = active_q;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Randomized bench: a scaled-down mode table checked every cycle against a position model,
// plus literal checks of the standard table on three default-table instances.
module tb_vga_timing_multi;
  import vga_pkg::*;

  // Scaled timing set: ADDR / SYNC_START / SYNC_TIME / TOTAL per axis, polarity 1 = positive.
  localparam int s_ha[3] = '{16, 12, 20};
  localparam int s_hs[3] = '{18, 13, 22};
  localparam int s_hw[3] = '{3, 2, 4};
  localparam int s_ht[3] = '{22, 15, 27};
  localparam int s_va[3] = '{6, 5, 8};
  localparam int s_vs[3] = '{7, 6, 9};
  localparam int s_vw[3] = '{2, 1, 3};
  localparam int s_vt[3] = '{9, 8, 11};
  localparam bit s_pos[3] = '{1'b1, 1'b0, 1'b0};

  localparam vga_mode_tbl_t SMALL_TBL = {
    mk_mode(20, 22, 4, 27, 8, 9, 3, 11, 1'b0, 1'b0),
    mk_mode(12, 13, 2, 15, 5, 6, 1, 8, 1'b0, 1'b0),
    mk_mode(16, 18, 3, 22, 6, 7, 2, 9, 1'b1, 1'b1)
  };

  // Standard table values, written out by hand.
  localparam int r_ha[3] = '{800, 640, 1024};
  localparam int r_hs[3] = '{840, 656, 1048};
  localparam int r_hw[3] = '{128, 96, 136};
  localparam int r_ht[3] = '{1056, 800, 1344};
  localparam bit r_pos[3] = '{1'b1, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n, rrst_n;
  logic [1:0]  mode_sel;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk, frame_start;
  logic [1:0]  active_mode;

  logic [1:0]  r_sel [3];
  logic [10:0] r_hc [3];
  logic [10:0] r_vc [3];
  logic        r_hs_o [3];
  logic        r_vs_o [3];
  logic        r_hb [3];
  logic        r_vb [3];
  logic        r_fs [3];
  logic [1:0]  r_am [3];

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  vga_timing_multi #(
    .MODE_TABLE (SMALL_TBL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_sel    (mode_sel),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblnk       (hblnk),
    .vblnk       (vblnk),
    .frame_start (frame_start),
    .active_mode (active_mode)
  );

  for (genvar g = 0; g < 3; g++) begin : g_real
    vga_timing_multi #(
      .RESET_MODE (g)
    ) u_real (
      .clk         (clk),
      .rst_n       (rrst_n),
      .mode_sel    (r_sel[g]),
      .hcount      (r_hc[g]),
      .vcount      (r_vc[g]),
      .hsync       (r_hs_o[g]),
      .vsync       (r_vs_o[g]),
      .hblnk       (r_hb[g]),
      .vblnk       (r_vb[g]),
      .frame_start (r_fs[g]),
      .active_mode (r_am[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(int c, int s, int w);
    return (c >= s) && (c < s + w);
  endfunction

  function automatic bit sync_lvl(bit act, bit pos);
`ifdef VGA_SYNC_POL_EN
    return pos ? act : !act;
`else
    return act | (pos & 1'b0);
`endif
  endfunction

  // Reference model: current pixel position, active/pending mode, frame-start flag.
  int m_h = 0, m_v = 0, m_act = 0, m_pend = 0;
  bit m_started = 1'b0, m_fs = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_act = 0; m_pend = 0; m_started = 1'b0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;
        m_fs = 1'b1;
      end else if (m_h == s_ht[m_act] - 1) begin
        m_h = 0;
        if (m_v == s_vt[m_act] - 1) begin
          m_v = 0;
          m_act = m_pend;
          m_fs = 1'b1;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
      if (int'(mode_sel) < 3) m_pend = int'(mode_sel);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("hcount", 32'(hcount), 32'(m_h));
      chk("vcount", 32'(vcount), 32'(m_v));
      chk("active_mode", 32'(active_mode), 32'(m_act));
      chk("frame_start", 32'(frame_start), 32'(m_fs));
      chk("hblnk", 32'(hblnk), 32'(m_h >= s_ha[m_act]));
      chk("vblnk", 32'(vblnk), 32'(m_v >= s_va[m_act]));
      chk("hsync", 32'(hsync), 32'(sync_lvl(in_win(m_h, s_hs[m_act], s_hw[m_act]), s_pos[m_act])));
      chk("vsync", 32'(vsync), 32'(sync_lvl(in_win(m_v, s_vs[m_act], s_vw[m_act]), s_pos[m_act])));
    end
  end

  // Counts negedges until the next frame_start; 2000 means none was seen.
  task automatic wait_fs(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < 2000);
  endtask

  initial begin
    int per;
    rst_n = 1'b0;
    rrst_n = 1'b0;
    mode_sel = 2'd0;
    for (int i = 0; i < 3; i++) r_sel[i] = 2'(i);
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_hcount", 32'(hcount), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_frame_start", 32'(frame_start), 32'd1);
    wait_fs(per);
    chk("period_mode0", 32'(per), 32'd198);

    // Request mode 1 mid-frame (line 4).
    repeat (88) @(negedge clk);
    mode_sel = 2'd1;
    chk("mode_held_midframe", 32'(active_mode), 32'd0);
    wait_fs(per);
    chk("switch_wait", 32'(per), 32'd110);
    chk("mode_after_switch", 32'(active_mode), 32'd1);
    wait_fs(per);
    chk("period_mode1", 32'(per), 32'd120);

    // Several requests in one frame; the last legal one (2) wins, 3 is ignored.
    mode_sel = 2'd0;
    repeat (20) @(negedge clk);
    mode_sel = 2'd2;
    repeat (20) @(negedge clk);
    mode_sel = 2'd3;
    repeat (20) @(negedge clk);
    wait_fs(per);
    chk("multi_req_wait", 32'(per), 32'd60);
    chk("mode_last_legal", 32'(active_mode), 32'd2);
    wait_fs(per);
    chk("period_mode2_illegal_sel", 32'(per), 32'd297);
    chk("mode_illegal_ignored", 32'(active_mode), 32'd2);

    // Request on the boundary cycle itself takes one more frame.
    repeat (296) @(negedge clk);
    mode_sel = 2'd0;
    @(negedge clk);
    mode_sel = 2'd3;
    chk("boundary_fs", 32'(frame_start), 32'd1);
    chk("boundary_req_deferred", 32'(active_mode), 32'd2);
    wait_fs(per);
    chk("boundary_req_period", 32'(per), 32'd297);
    chk("boundary_req_applied", 32'(active_mode), 32'd0);

    // One-cycle reset mid-frame.
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_hcount", 32'(hcount), 32'd0);
    chk("midreset_fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    chk("midreset_release_fs", 32'(frame_start), 32'd1);

    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) mode_sel = 2'($urandom_range(3));
      rst_n = ($urandom_range(2999) != 0);
    end
    rst_n = 1'b1;

    // Standard table: first lines after reset of each mode.
    @(negedge clk);
    rrst_n = 1'b0;
    @(negedge clk);
    rrst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2700; k++) begin
      for (int g = 0; g < 3; g++) begin
        chk("real_hcount", 32'(r_hc[g]), 32'(k % r_ht[g]));
        chk("real_vcount", 32'(r_vc[g]), 32'(k / r_ht[g]));
        chk("real_hsync", 32'(r_hs_o[g]),
            32'(sync_lvl(in_win(k % r_ht[g], r_hs[g], r_hw[g]), r_pos[g])));
        chk("real_vsync", 32'(r_vs_o[g]), 32'(sync_lvl(1'b0, r_pos[g])));
        chk("real_hblnk", 32'(r_hb[g]), 32'((k % r_ht[g]) >= r_ha[g]));
        chk("real_vblnk", 32'(r_vb[g]), 32'd0);
        chk("real_frame_start", 32'(r_fs[g]), 32'(k == 0));
        chk("real_active_mode", 32'(r_am[g]), 32'(g));
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_multi.md
Name: vga_timing_multi

Overview:
Multi-mode VGA timing generator: next generation of the fixed 800x600@60 timing set, with the mode chosen at run time from a table of resolutions. Produces registered hcount/vcount, sync and blanking signals consumed by the draw pipeline (background, rect, char/font drawing). Mode changes take effect only at a frame boundary, so a frame never mixes two timings. Pixel clock frequency is supplied externally to match the selected mode.

Parameters:
- CNT_WIDTH, 11, width of hcount/vcount (must hold max H_TOTAL-1 = 1343)
- NUM_MODES, 3, number of table entries; legal mode_sel range 0..NUM_MODES-1
- RESET_MODE, 0, mode index active after reset

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous reset, active low
- mode_sel  in  2  requested mode index
- hcount  out  CNT_WIDTH  horizontal pixel position
- vcount  out  CNT_WIDTH  vertical line position
- hsync  out  1  horizontal sync, mode polarity
- vsync  out  1  vertical sync, mode polarity
- hblnk  out  1  high when hcount >= H_ADDR
- vblnk  out  1  high when vcount >= V_ADDR
- frame_start  out  1  one-cycle pulse with hcount==0 && vcount==0
- active_mode  out  2  mode index currently driving the timing

Behaviour:
- Reset (rst_n==0 at clk edge): hcount=0, vcount=0, active_mode=RESET_MODE, pending mode=RESET_MODE, hblnk=0, vblnk=0, frame_start=0, hsync/vsync = inactive level of RESET_MODE (0 for mode 0). Reset mid-frame restarts at (0,0) immediately.
- Counting: hcount increments each cycle; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 wraps to 0 on the same cycle hcount wraps.
- All outputs registered; flags are derived from the next count values so every output describes the same pixel in the same cycle (zero skew between counts and flags).
- hsync asserted for H_SYNC_START <= hcount < H_SYNC_START+H_SYNC_TIME; vsync likewise on vcount with V_SYNC_*.
- mode_sel sampled every cycle into a pending register; values >= NUM_MODES are ignored (pending unchanged).
- Mode switch: when hcount==H_TOTAL-1 && vcount==V_TOTAL-1 of the active mode, active_mode <= pending; the wrap to (0,0) uses the new mode's table from that cycle. Request arriving on the boundary cycle itself is applied at the next boundary.
- frame_start asserted on the first cycle after reset release and on every wrap to (0,0).
- Mode table (entries in package):
  0: 800x600@60, 40 MHz: H 800/840/128/1056, V 600/601/4/628, pos/pos
  1: 640x480@60, 25.175 MHz: H 640/656/96/800, V 480/490/2/525, neg/neg
  2: 1024x768@60, 65 MHz: H 1024/1048/136/1344, V 768/771/6/806, neg/neg
  (format: ADDR/SYNC_START/SYNC_TIME/TOTAL)

Optional Feature:
VGA_SYNC_POL_EN — defined: hsync/vsync driven with the per-mode polarity bit (negative = active-low). Not defined: polarity bits ignored, syncs always active-high for every mode; reset level 0.

Decomposition:
- vga_pkg gains: typedef struct packed vga_mode_t {h_addr, h_sync_start, h_sync_time, h_total, v_addr, v_sync_start, v_sync_time, v_total, h_pol, v_pol}; localparam vga_mode_t VGA_MODES[3]; MODE_* index constants. Existing single-mode constants stay as mode 0 aliases.
- One sub-module: vga_axis_cnt (one instance per axis): counter with enable, terminal value, sync window and blank compare, registered outputs.

Test Plan:
- Reset, mode 0, run 1 frame -> hcount wraps at 1055, vcount at 627; hsync high exactly hcount 840..967; vsync high vcount 601..604; 663168 clocks between frame_start pulses.
- mode_sel=1 mid-frame (vcount=300) -> active_mode stays 0 until (1055,627), then 1; next frame period 420000 clocks; with VGA_SYNC_POL_EN hsync low for hcount 656..751.
- mode_sel=3 (illegal) while in mode 2 -> ignored; active_mode stays 2, period 1083264 clocks.
- mode_sel changes 0->2->1 within one frame -> only last legal value (1) applied at boundary.
- rst_n low at (500,300) for one cycle -> next cycle hcount=0, vcount=0, active_mode=0, all flags reset values; frame_start pulses on release.
- Blanking check mode 2 -> hblnk high exactly hcount 1024..1343, vblnk high vcount 768..805, aligned with counts (no one-cycle skew).
